// File: rtl/aes_out_fifo_axis_tx.sv
`default_nettype none
// ============================================================================
//  Module      : aes_out_fifo_axis_tx
//  Description : Drains the AES output FIFO after a command batch completes
//                and streams each FIFO entry out as AXIS words, most
//                significant word first, with tlast closing the batch.
//  Options     : AES_TX_TLAST_PER_BLK_EN - when defined, tlast also closes
//                every AES block (one packet per block).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_out_fifo_axis_tx #(
  parameter int OUT_FIFO_ADDR_WIDTH = 9,
  parameter int OUT_FIFO_DATA_WIDTH = 128,
  parameter int AXIS_DATA_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic [OUT_FIFO_ADDR_WIDTH-1:0] blk_cnt,
  input  logic [OUT_FIFO_DATA_WIDTH-1:0] out_fifo_data,
  output logic                           out_fifo_r_e,
  output logic [OUT_FIFO_ADDR_WIDTH-1:0] out_fifo_addr,
  output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           busy,
  output logic                           en_o
);

  // Words per FIFO entry and the width of the word counter.
  localparam int c_words = OUT_FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
  localparam int c_idx_w = (c_words > 1) ? $clog2(c_words) : 1;
  localparam logic [c_idx_w-1:0]             c_last_idx = c_idx_w'(c_words - 1);
  localparam logic [c_idx_w-1:0]             c_idx_one  = c_idx_w'(1);
  localparam logic [OUT_FIFO_ADDR_WIDTH-1:0] c_ptr_one  = OUT_FIFO_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_LOAD    = 2'd2,
    S_SEND    = 2'd3
  } state_t;

  state_t                         r_state;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] r_cnt;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [OUT_FIFO_ADDR_WIDTH-1:0] r_addr;
  logic [OUT_FIFO_DATA_WIDTH-1:0] r_shreg;
  logic [c_idx_w-1:0]             r_word_idx;
  logic                           r_rd_en;
  logic                           r_tvalid;
  logic                           r_busy;
  logic                           r_en_o;

  logic [AXIS_DATA_WIDTH-1:0]     w_word;
  logic                           w_last_word;
  logic                           w_last_blk;
  logic                           w_tlast;

  // Word k of an entry is the k-th AXIS word counted from the top bits,
  // so the leftmost hex word of the entry leaves first.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < c_words; k++) begin
      if (r_word_idx == c_idx_w'(k)) begin
        w_word = r_shreg[OUT_FIFO_DATA_WIDTH-1-k*AXIS_DATA_WIDTH -: AXIS_DATA_WIDTH];
      end
    end
  end

  // cnt is never zero outside IDLE, so cnt-1 cannot wrap here.
  assign w_last_word = (r_word_idx == c_last_idx);
  assign w_last_blk  = (r_rd_ptr == (r_cnt - c_ptr_one));

`ifdef AES_TX_TLAST_PER_BLK_EN
  assign w_tlast = r_tvalid & w_last_word;
`else
  assign w_tlast = r_tvalid & w_last_word & w_last_blk;
`endif

  // Control FSM: batch start, per-block FIFO read, word-by-word streaming.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rd_ptr   <= '0;
      r_addr     <= '0;
      r_shreg    <= '0;
      r_word_idx <= '0;
      r_rd_en    <= 1'b0;
      r_tvalid   <= 1'b0;
      r_busy     <= 1'b0;
      r_en_o     <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_en_o  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_cnt <= blk_cnt;
            if (blk_cnt == '0) begin
              r_en_o <= 1'b1;
            end else begin
              r_rd_en  <= 1'b1;
              r_addr   <= '0;
              r_rd_ptr <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shreg    <= out_fifo_data;
          r_word_idx <= '0;
          r_tvalid   <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (r_tvalid && m_axis_tready) begin
            if (w_last_word) begin
              r_word_idx <= '0;
              r_tvalid   <= 1'b0;
              if (w_last_blk) begin
                r_busy  <= 1'b0;
                r_en_o  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_addr   <= r_rd_ptr + c_ptr_one;
                r_rd_en  <= 1'b1;
                r_state  <= S_RD_WAIT;
              end
            end else begin
              r_word_idx <= r_word_idx + c_idx_one;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_fifo_r_e  = r_rd_en;
  assign out_fifo_addr = r_addr;
  assign m_axis_tdata  = r_tvalid ? w_word : '0;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = w_tlast;
  assign busy          = r_busy;
  assign en_o          = r_en_o;

endmodule
`default_nettype wire

// File: tb/tb_aes_out_fifo_axis_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_out_fifo_axis_tx
//  Description : Self-checking bench for aes_out_fifo_axis_tx. A queue model
//                of the expected word stream is built from the FIFO contents
//                and compared on every handshake; directed tests pin timing.
//  Options     : AES_TX_TLAST_PER_BLK_EN selects the expected tlast pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_out_fifo_axis_tx;

  localparam int AW  = 9;
  localparam int DW  = 128;
  localparam int ADW = 32;
  localparam int W   = DW / ADW;
`ifdef AES_TX_TLAST_PER_BLK_EN
  localparam bit PER_BLK = 1'b1;
`else
  localparam bit PER_BLK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [AW-1:0] blk_cnt;
  logic [DW-1:0] out_fifo_data;
  logic          out_fifo_r_e;
  logic [AW-1:0] out_fifo_addr;
  logic [ADW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic          en_o;

  aes_out_fifo_axis_tx #(
    .OUT_FIFO_ADDR_WIDTH(AW),
    .OUT_FIFO_DATA_WIDTH(DW),
    .AXIS_DATA_WIDTH    (ADW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .blk_cnt      (blk_cnt),
    .out_fifo_data(out_fifo_data),
    .out_fifo_r_e (out_fifo_r_e),
    .out_fifo_addr(out_fifo_addr),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .en_o         (en_o)
  );

  always #5 clk = ~clk;

  // FIFO memory: read data appears one cycle after the read enable.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (out_fifo_r_e) out_fifo_data <= mem[out_fifo_addr];
  end

  typedef struct {
    logic [ADW-1:0] d;
    logic           l;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int n_reads = 0;
  int exp_rd  = 0;
  int n_en_o  = 0;
  int n_tlast = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle compare against the model, sampled mid-cycle.
  logic           prev_stall = 1'b0;
  logic [ADW-1:0] prev_data;
  logic           prev_last;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", m_axis_tvalid, 1'b1);
        check("stall_tdata", m_axis_tdata, prev_data);
        check("stall_tlast", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        if (m_axis_tlast) n_tlast++;
        if (exp_q.size() == 0) begin
          check("extra_word", m_axis_tdata, 128'hDEAD);
        end else begin
          check("tdata", m_axis_tdata, exp_q[0].d);
          check("tlast", m_axis_tlast, exp_q[0].l);
          void'(exp_q.pop_front());
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      if (out_fifo_r_e) begin
        check("rd_addr", out_fifo_addr, exp_rd);
        exp_rd++;
        n_reads++;
      end
      if (en_o) n_en_o++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      mem[i] = {seed + 32'(i*4), seed + 32'(i*4+1), seed + 32'(i*4+2), seed + 32'(i*4+3)};
    end
  endtask

  // Build the expected stream from FIFO contents, then pulse en.
  task automatic start_batch(input int n);
    logic [DW-1:0] e;
    exp_t x;
    for (int b = 0; b < n; b++) begin
      e = mem[b];
      for (int w = 0; w < W; w++) begin
        x.d = e[DW-1-w*ADW -: ADW];
        x.l = (w == W-1) && (PER_BLK || (b == n-1));
        exp_q.push_back(x);
      end
    end
    hs_cnt  = 0;
    n_reads = 0;
    exp_rd  = 0;
    n_tlast = 0;
    en      = 1'b1;
    blk_cnt = AW'(n);
    tick();
    en      = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i = 0;
    while (en_o !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    check(name, en_o, 1'b1);
    check({name, "_q_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int i = 0;
    while (hs_cnt < target && i < budget) begin
      tick();
      i++;
    end
    check("wait_hs", hs_cnt, target);
  endtask

  int en_o_before;

  initial begin
    reset = 1'b1;
    en = 1'b0;
    blk_cnt = '0;
    m_axis_tready = 1'b1;
    out_fifo_data = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (3) tick();
    // Reset state
    check("rst_r_e", out_fifo_r_e, 1'b0);
    check("rst_addr", out_fifo_addr, 0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_en_o", en_o, 1'b0);
    reset = 1'b0;
    tick();

    // 1 block, exact cycle timing
    mem[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    start_batch(1);
    check("t1_c1_r_e", out_fifo_r_e, 1'b1);
    check("t1_c1_addr", out_fifo_addr, 0);
    check("t1_c1_busy", busy, 1'b1);
    check("t1_c1_tvalid", m_axis_tvalid, 1'b0);
    tick();
    check("t1_c2_r_e", out_fifo_r_e, 1'b0);
    check("t1_c2_tvalid", m_axis_tvalid, 1'b0);
    tick();
    check("t1_c3_tvalid", m_axis_tvalid, 1'b1);
    check("t1_c3_tdata", m_axis_tdata, 32'h00112233);
    check("t1_c3_tlast", m_axis_tlast, 1'b0);
    tick();
    check("t1_c4_tdata", m_axis_tdata, 32'h44556677);
    tick();
    check("t1_c5_tdata", m_axis_tdata, 32'h8899aabb);
    check("t1_c5_tlast", m_axis_tlast, 1'b0);
    tick();
    check("t1_c6_tdata", m_axis_tdata, 32'hccddeeff);
    check("t1_c6_tlast", m_axis_tlast, 1'b1);
    tick();
    check("t1_c7_en_o", en_o, 1'b1);
    check("t1_c7_tvalid", m_axis_tvalid, 1'b0);
    check("t1_c7_busy", busy, 1'b0);
    check("t1_reads", n_reads, 1);
    check("t1_q_empty", exp_q.size(), 0);
    repeat (2) tick();

    // 3 blocks, full throughput
    fill(3, 32'h1000_0000);
    en_o_before = n_en_o;
    start_batch(3);
    wait_done("t2_done", 100);
    tick();
    check("t2_words", hs_cnt, 12);
    check("t2_reads", n_reads, 3);
    check("t2_tlast_cnt", n_tlast, PER_BLK ? 3 : 1);
    check("t2_en_o_cnt", n_en_o - en_o_before, 1);
    repeat (2) tick();

    // Backpressure on word 2 for five cycles
    mem[0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    mem[1] = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;
    start_batch(2);
    wait_hs(1, 20);
    m_axis_tready = 1'b0;
    repeat (5) begin
      check("t3_hold_tdata", m_axis_tdata, 32'h44556677);
      tick();
    end
    m_axis_tready = 1'b1;
    wait_done("t3_done", 100);
    tick();
    check("t3_words", hs_cnt, 8);
    repeat (2) tick();

    // Zero-length batch
    en_o_before = n_en_o;
    start_batch(0);
    check("t4_en_o", en_o, 1'b1);
    check("t4_busy", busy, 1'b0);
    check("t4_tvalid", m_axis_tvalid, 1'b0);
    repeat (5) tick();
    check("t4_reads", n_reads, 0);
    check("t4_words", hs_cnt, 0);
    check("t4_en_o_cnt", n_en_o - en_o_before, 1);

    // en re-pulsed while busy is ignored
    fill(2, 32'h2000_0000);
    en_o_before = n_en_o;
    start_batch(2);
    repeat (3) tick();
    en = 1'b1;
    blk_cnt = AW'(7);
    tick();
    en = 1'b0;
    wait_done("t5_done", 100);
    repeat (10) tick();
    check("t5_reads", n_reads, 2);
    check("t5_words", hs_cnt, 8);
    check("t5_en_o_cnt", n_en_o - en_o_before, 1);
    check("t5_busy", busy, 1'b0);

    // Reset during word 3 of the first block of four
    fill(4, 32'h3000_0000);
    en_o_before = n_en_o;
    start_batch(4);
    wait_hs(2, 20);
    check("t6_pre_tdata", m_axis_tdata, 32'h3000_0002);
    reset = 1'b1;
    tick();
    check("t6_tvalid", m_axis_tvalid, 1'b0);
    check("t6_tdata", m_axis_tdata, 0);
    check("t6_tlast", m_axis_tlast, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_r_e", out_fifo_r_e, 1'b0);
    check("t6_addr", out_fifo_addr, 0);
    check("t6_en_o", en_o, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    repeat (20) tick();
    check("t6_no_en_o", n_en_o - en_o_before, 0);
    check("t6_idle_tvalid", m_axis_tvalid, 1'b0);
    mem[0] = 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004;
    start_batch(1);
    check("t6_restart_addr", out_fifo_addr, 0);
    wait_done("t6_restart_done", 50);
    tick();
    check("t6_restart_words", hs_cnt, 4);
    check("t6_restart_reads", n_reads, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
